// File: rtl/md_issue_queue.sv
// md_issue_queue: in-order buffer of mult/multu/div/divu/mthi/mtlo ops feeding the HI/LO multiply/divide unit.
// Latency: accepted at edge N, issued earliest in cycle N+1; zero-cycle issue into an empty idle queue when MDQ_BYPASS_EN is defined.
// Backpressure: in_ready drops while full, head issues only while xalu_busy is low, stall freezes F/D/E for pending HI/LO reads.
module md_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             flush,
    input  logic             hilo_read,
    output logic             stall,
    output logic [3:0]       xalu_op,
    output logic [31:0]      xalu_in1,
    output logic [31:0]      xalu_in2,
    output logic             xalu_hlwr,
    input  logic             xalu_busy,
    output logic             illegal_op,
    output logic [PTR_W:0]   occupancy
);

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic   op_legal;
    logic   q_empty;
    logic   accept;
    logic   push;
    logic   pop;
    logic   bypass;
    entry_t new_ent;
    entry_t head;
    entry_t issue;

    // Decode the six HI/LO op codes the unit understands.
    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // in_ready depends only on registered occupancy, so a pop never opens a slot in the same cycle.
    assign in_ready = (occupancy != OCC_FULL);
    assign q_empty  = (occupancy == '0);
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = ~q_empty & ~xalu_busy & ~flush;

`ifdef MDQ_BYPASS_EN
    // Empty, idle queue: hand the incoming op straight to the unit without storing it.
    assign bypass = q_empty & in_valid & op_legal & ~xalu_busy & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // Illegal ops are consumed but never stored; bypassed ops skip storage.
    assign push = accept & op_legal & ~bypass;

    assign new_ent   = '{op: in_op, a: in_a, b: in_b};
    assign head      = mem[rd_ptr];
    assign issue     = bypass ? new_ent : head;
    assign xalu_op   = issue.op;
    assign xalu_in1  = issue.a;
    assign xalu_in2  = issue.b;
    assign xalu_hlwr = pop | bypass;

    // mfhi/mflo must wait until nothing older is queued or still running; a blocked producer also holds the pipe.
    assign stall = (hilo_read & (~q_empty | xalu_busy)) | (in_valid & ~in_ready);

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_ent;
        end
    end

    // Pointers, occupancy and illegal-op pulse; flush drops every unissued entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occupancy  <= '0;
            illegal_op <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= wr_ptr;
            occupancy  <= '0;
            illegal_op <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push & ~pop) begin
                occupancy <= occupancy + OCC_ONE;
            end else if (pop & ~push) begin
                occupancy <= occupancy - OCC_ONE;
            end
            illegal_op <= accept & ~op_legal;
        end
    end

endmodule
